// File: rtl/align_pkg.sv
// Shared types and helpers for the fetch-side instruction realigner.
// Parcels are 16-bit halves of fetch words; length is decided from the head parcel.
package align_pkg;

    localparam int PARCEL_W = 16;
    localparam int NPARCELS = 4;

    typedef logic [PARCEL_W-1:0] parcel_t;

    // Anything with low bits 2'b11 is taken as 32-bit; longer forms fault in decode.
    function automatic logic is_32bit(input parcel_t parcel);
        return parcel[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/parcel_queue.sv
// Four-entry shift queue of 16-bit parcels with 0/1/2 pop and push per cycle.
// Pop is applied first; pushed parcels land at the post-pop tail.
module parcel_queue
    import align_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic [1:0]    i_pop_n,
    input  logic [1:0]    i_push_n,
    input  parcel_t       i_push0,
    input  parcel_t       i_push1,
    output logic [2:0]    o_count,
    output parcel_t       o_head0,
    output parcel_t       o_head1
);

    parcel_t    q_q [NPARCELS];
    parcel_t    q_d [NPARCELS];
    logic [2:0] count_q;
    logic [2:0] count_d;
    logic [2:0] mid;
    logic [1:0] tail0;
    logic [1:0] tail1;

    assign mid   = count_q - {1'b0, i_pop_n};
    assign tail0 = mid[1:0];
    assign tail1 = mid[1:0] + 2'd1;

    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else begin
            unique case (i_pop_n)
                2'd1:    q_d = '{q_q[1], q_q[2], q_q[3], '0};
                2'd2:    q_d = '{q_q[2], q_q[3], '0, '0};
                default: q_d = q_q;
            endcase
            if (i_push_n != 2'd0) begin
                q_d[tail0] = i_push0;
            end
            if (i_push_n == 2'd2) begin
                q_d[tail1] = i_push1;
            end
            count_d = mid + {1'b0, i_push_n};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
            for (int i = 0; i < NPARCELS; i++) begin
                q_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            q_q     <= q_d;
        end
    end

    assign o_count = count_q;
    assign o_head0 = q_q[0];
    assign o_head1 = q_q[1];

endmodule

// File: rtl/instr_aligner.sv
// Splits word-aligned fetch data into parcels and emits one whole,
// left-justified instruction per cycle with its PC.
module instr_aligner
    import align_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_fetch_valid,
    input  logic [31:0] i_fetch_data,
    output logic        o_fetch_ready,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_instr_ready
);

    logic [2:0]  count;
    parcel_t     head0;
    parcel_t     head1;
    logic        head_is32;
    logic        fetch_fire;
    logic        out_fire;
    logic [1:0]  pop_n;
    logic [1:0]  push_n;
    parcel_t     push0;
    parcel_t     push1;
    logic [30:0] head_pc_q;
    logic [30:0] head_pc_d;
    logic        drop_lo_q;
    logic        drop_lo_d;

    assign head_is32     = is_32bit(head0);
    assign o_fetch_ready = (count <= 3'd2);
    assign o_instr_valid = (count != 3'd0) &&
                           (!head_is32 || count >= 3'd2);
    assign o_pc          = {head_pc_q, 1'b0};

    assign fetch_fire = i_fetch_valid & o_fetch_ready & ~i_redirect;
    assign out_fire   = o_instr_valid & i_instr_ready & ~i_redirect;

    always_comb begin
        o_instr = {16'h0, head0};
        if (head_is32 || count >= 3'd2) begin
            o_instr = {head1, head0};
        end
    end

    always_comb begin
        pop_n  = 2'd0;
        push_n = 2'd0;
        push0  = i_fetch_data[15:0];
        push1  = i_fetch_data[31:16];
        if (out_fire) begin
            pop_n = head_is32 ? 2'd2 : 2'd1;
        end
        if (fetch_fire) begin
            push_n = drop_lo_q ? 2'd1 : 2'd2;
        end
        // A half-word redirect target skips the low parcel of its first word.
        if (drop_lo_q) begin
            push0 = i_fetch_data[31:16];
        end
    end

    always_comb begin
        head_pc_d = head_pc_q;
        drop_lo_d = drop_lo_q;
        if (i_redirect) begin
            head_pc_d = i_redirect_pc[31:1];
            drop_lo_d = i_redirect_pc[1];
        end else begin
            if (out_fire) begin
                head_pc_d = head_pc_q + (head_is32 ? 31'd2 : 31'd1);
            end
            if (fetch_fire) begin
                drop_lo_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_pc_q <= RESET_PC[31:1];
            drop_lo_q <= RESET_PC[1];
        end else begin
            head_pc_q <= head_pc_d;
            drop_lo_q <= drop_lo_d;
        end
    end

    parcel_queue u_queue (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (i_redirect),
        .i_pop_n  (pop_n),
        .i_push_n (push_n),
        .i_push0  (push0),
        .i_push1  (push1),
        .o_count  (count),
        .o_head0  (head0),
        .o_head1  (head1)
    );

endmodule

// File: tb/tb_instr_aligner.sv
// Directed bench for instr_aligner: expected instructions are queued as
// stimulus is issued and a negedge monitor checks each output handshake.
module tb_instr_aligner;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_data = '0;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_ready = 1'b0;

    int total = 0;
    int bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    instr_aligner #(.RESET_PC(32'h8000_0000)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_fetch_valid (fetch_valid),
        .i_fetch_data  (fetch_data),
        .o_fetch_ready (fetch_ready),
        .o_instr_valid (instr_valid),
        .o_instr       (instr),
        .o_pc          (pc),
        .i_instr_ready (instr_ready)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // One clock with the given inputs; returns 1ns after the edge.
    task automatic step(input logic fv, input logic [31:0] fd,
                        input logic rdy, input logic rd = 1'b0,
                        input logic [31:0] rpc = '0,
                        input logic rs = 1'b0);
        fetch_valid = fv;
        fetch_data  = fd;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        rst         = rs;
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic expect_instr(input logic [31:0] i, input logic [31:0] p);
        exp_q.push_back('{instr: i, pc: p});
    endtask

    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready && !redirect) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got %h @%h want none", instr, pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_instr", instr, e.instr);
                check("sb_pc", pc, e.pc);
            end
        end
    end

    logic [31:0] held_i;
    logic [31:0] held_pc;

    initial begin
        // Reset values
        step(0, '0, 0, 0, '0, 1);
        step(0, '0, 0, 0, '0, 1);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_ready", {31'b0, fetch_ready}, 32'd1);

        // Aligned 32-bit instruction
        step(1, 32'h0051_0113, 0);
        expect_instr(32'h0051_0113, 32'h8000_0000);
        check("t1_valid", {31'b0, instr_valid}, 32'd1);
        step(0, '0, 1);
        check("t1_empty", {31'b0, instr_valid}, 32'd0);
        check("t1_fready", {31'b0, fetch_ready}, 32'd1);

        // Two compressed, then fill to count 4 and drain
        step(1, 32'h4505_4501, 0);
        check("t2_fready2", {31'b0, fetch_ready}, 32'd1);
        step(1, 32'h0051_0113, 0);
        expect_instr(32'h4505_4501, 32'h8000_0004);
        expect_instr(32'h0113_4505, 32'h8000_0006);
        expect_instr(32'h0051_0113, 32'h8000_0008);
        check("t2_fready4", {31'b0, fetch_ready}, 32'd0);
        step(0, '0, 1);
        check("t2_fready3", {31'b0, fetch_ready}, 32'd0);
        step(0, '0, 1);
        check("t2_fready2b", {31'b0, fetch_ready}, 32'd1);
        step(0, '0, 1);
        check("t2_empty", {31'b0, instr_valid}, 32'd0);

        // Straddling 32-bit instruction
        step(1, 32'h0113_4501, 1);
        expect_instr(32'h0113_4501, 32'h8000_000c);
        step(0, '0, 1);
        check("t3_half", {31'b0, instr_valid}, 32'd0);
        step(1, 32'hdead_0051, 1);
        expect_instr(32'h0051_0113, 32'h8000_000e);
        expect_instr(32'h0000_dead, 32'h8000_0012);
        step(0, '0, 1);
        step(0, '0, 1);
        check("t3_empty", {31'b0, instr_valid}, 32'd0);

        // Redirect to a half-word target drops the low parcel
        step(0, '0, 0, 1, 32'h8000_0106);
        check("t4_valid", {31'b0, instr_valid}, 32'd0);
        check("t4_pc", pc, 32'h8000_0106);
        step(1, 32'h4585_beef, 0);
        expect_instr(32'h0000_4585, 32'h8000_0106);
        check("t4_instr", instr, 32'h0000_4585);
        step(0, '0, 1);

        // Stall with pushes pending
        step(1, 32'h00a0_0593, 0);
        held_i  = instr;
        held_pc = pc;
        check("t5_first", instr, 32'h00a0_0593);
        step(1, 32'h4505_4501, 0);
        check("t5_hold_i1", instr, held_i);
        check("t5_hold_pc1", pc, held_pc);
        check("t5_full", {31'b0, fetch_ready}, 32'd0);
        step(1, 32'h1111_1111, 0);
        check("t5_hold_i2", instr, held_i);
        check("t5_hold_pc2", pc, held_pc);
        step(0, '0, 0);
        check("t5_hold_i3", instr, held_i);
        expect_instr(32'h00a0_0593, 32'h8000_0108);
        expect_instr(32'h4505_4501, 32'h8000_010c);
        expect_instr(32'h0000_4505, 32'h8000_010e);
        step(0, '0, 1);
        step(0, '0, 1);
        step(0, '0, 1);
        check("t5_empty", {31'b0, instr_valid}, 32'd0);

        // Redirect beats simultaneous fetch and output handshakes
        step(1, 32'h0051_0113, 0);
        check("t6_valid", {31'b0, instr_valid}, 32'd1);
        step(1, 32'h4505_4501, 1, 1, 32'h8000_0200);
        check("t6_flush", {31'b0, instr_valid}, 32'd0);
        check("t6_pc", pc, 32'h8000_0200);
        check("t6_fready", {31'b0, fetch_ready}, 32'd1);

        // PC wraps past the top of the address space
        step(0, '0, 0, 1, 32'hffff_fffe);
        step(1, 32'h4501_0000, 0);
        expect_instr(32'h0000_4501, 32'hffff_fffe);
        step(0, '0, 1);
        check("t7_wrap", pc, 32'h0000_0000);

        // Mid-stream reset overrides a redirect
        step(1, 32'h0051_0113, 0);
        check("t8_instr", instr, 32'h0051_0113);
        step(1, 32'h4505_4501, 1, 1, 32'h1234_5678, 1);
        check("t8_valid", {31'b0, instr_valid}, 32'd0);
        check("t8_instr0", instr, 32'h0);
        check("t8_pc", pc, 32'h8000_0000);
        check("t8_fready", {31'b0, fetch_ready}, 32'd1);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
